// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } rx_state_t;

  localparam int DATA_BITS_DEF = 8;
  localparam int TIMEOUT_DEF   = 32;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous level input; resets to 1 so an
// idle-high line does not look active out of reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a recovered mid-bit clock (sck) in the 16x clk
// domain. Holds each good byte with a valid/ack handshake, flags stop-bit
// errors and overruns, and abandons a frame if sck stalls mid-frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 sck,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam int TOW = $clog2(TIMEOUT + 1);

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic                   w_rxs;
  logic                   r_sck_d;
  logic                   w_tick;
  logic                   w_timeout;
  logic                   w_load;
  logic                   w_ferr;
  logic [BCW-1:0]         r_bit_cnt;
  logic [TOW-1:0]         r_to_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_data_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  sync2 u_sync_rx (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rxs)
  );

  // sck is already in the clk domain; delay it once for rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) r_sck_d <= 1'b0;
    else     r_sck_d <= sck;
  end

  assign w_tick    = sck & ~r_sck_d;
  assign w_timeout = (r_to_cnt == TOW'(TIMEOUT));

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and single-cycle load / frame-error strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick && !w_rxs) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BCW'(DATA_BITS - 1)) w_state_nxt = STOP;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (w_rxs) begin
            w_load      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = BREAK;
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end
      end
      BREAK: begin
        // Only a high sample releases the line; a held-low line is not a start.
        if (w_tick && w_rxs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit counter: cleared at the start bit, advanced per sampled data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
    end else if (r_state == IDLE && w_tick && !w_rxs) begin
      r_bit_cnt <= '0;
    end else if (r_state == DATA && w_tick) begin
      r_bit_cnt <= r_bit_cnt + BCW'(1);
    end
  end

  // Stall counter: cleared by every tick, saturates so it never wraps.
  always_ff @(posedge clk) begin
    if (rst)             r_to_cnt <= '0;
    else if (w_tick)     r_to_cnt <= '0;
    else if (!w_timeout) r_to_cnt <= r_to_cnt + TOW'(1);
  end

  // Shift register: LSB arrives first, so new bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (r_state == DATA && w_tick) r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
  end

  // Output holding register and handshake; a load takes priority over ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_load) begin
        r_data       <= r_shift;
        r_data_valid <= 1'b1;
        if (r_data_valid && !data_ack) r_overrun <= 1'b1;
      end else if (data_ack && r_data_valid) begin
        r_data_valid <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a bit-rate stimulus generator drives rx and a
// mid-bit sck (16 clk per bit), a monitor records loads and frame errors.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       sck;
  logic       data_ack;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         n_fe   = 0;
  logic       dv_q   = 1'b0;
  logic       ack_en = 1'b0;
  logic [7:0] loads[$];
  int         fe0;
  int         l0;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .TIMEOUT(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .sck        (sck),
    .data       (data),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer: acks whenever enabled and a byte is held.
  initial begin
    data_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      data_ack = ack_en & data_valid;
    end
  end

  // Monitor: log every data_valid rise and every frame_err cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (data_valid && !dv_q) loads.push_back(data);
      if (frame_err) n_fe++;
      dv_q = data_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rx  = b;
      sck = (i >= 8);
    end
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(stop_b);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack_en = 1'b1;
    @(negedge clk);
    ack_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1;
    rx  = 1'b1;
    sck = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data",  32'(data),       32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_ferr",  32'(frame_err),  32'h0);
    chk("rst_ovr",   32'(overrun),    32'h0);
    rst = 1'b0;
    idle_bits(2);

    // 0xA5 with data_valid edge timing on the stop bit.
    v = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rx  = 1'b1;
      sck = (i >= 8);
      if (i == 8) chk("a5_valid_before_tick", 32'(data_valid), 32'h0);
      if (i == 9) chk("a5_valid_after_tick",  32'(data_valid), 32'h1);
    end
    chk("a5_data",  32'(data),       32'hA5);
    chk("a5_valid", 32'(data_valid), 32'h1);
    chk("a5_ferr",  32'(n_fe),       32'h0);
    do_ack();
    chk("a5_ack_clear", 32'(data_valid), 32'h0);

    // Back-to-back 0x00, 0xFF with a consumer acking each byte.
    loads.delete();
    ack_en = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(1);
    ack_en = 1'b0;
    chk("b2b_loads", 32'(loads.size()), 32'd2);
    chk("b2b_first",  (loads.size() > 0) ? 32'(loads[0]) : 32'hDEAD, 32'h00);
    chk("b2b_second", (loads.size() > 1) ? 32'(loads[1]) : 32'hDEAD, 32'hFF);
    chk("b2b_ovr",   32'(overrun),    32'h0);
    chk("b2b_valid", 32'(data_valid), 32'h0);

    // Overrun: 0x3C unacked, then 0xC3.
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    chk("ovr_first_data", 32'(data),    32'h3C);
    chk("ovr_first_ovr",  32'(overrun), 32'h0);
    send_frame(8'hC3, 1'b1);
    idle_bits(1);
    chk("ovr_data",  32'(data),       32'hC3);
    chk("ovr_flag",  32'(overrun),    32'h1);
    chk("ovr_valid", 32'(data_valid), 32'h1);
    do_ack();
    chk("ovr_ack_valid", 32'(data_valid), 32'h0);
    chk("ovr_ack_flag",  32'(overrun),    32'h0);

    // Stop bit low followed by a 40-bit break.
    fe0 = n_fe;
    l0  = loads.size();
    send_frame(8'h00, 1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    idle_bits(2);
    chk("brk_ferr_cycles", 32'(n_fe - fe0),         32'd1);
    chk("brk_loads",       32'(loads.size() - l0),  32'd0);
    chk("brk_valid",       32'(data_valid),         32'h0);
    send_frame(8'h55, 1'b1);
    idle_bits(1);
    chk("brk_next_data",  32'(data),       32'h55);
    chk("brk_next_valid", 32'(data_valid), 32'h1);
    do_ack();

    // sck stalls for 40 clk after three data bits.
    idle_bits(1);
    fe0 = n_fe;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sck = 1'b0;
    end
    chk("to_data",  32'(data),         32'h55);
    chk("to_valid", 32'(data_valid),   32'h0);
    chk("to_ovr",   32'(overrun),      32'h0);
    chk("to_ferr",  32'(n_fe - fe0),   32'd0);
    idle_bits(2);
    send_frame(8'h81, 1'b1);
    idle_bits(1);
    chk("to_next_data",  32'(data),       32'h81);
    chk("to_next_valid", 32'(data_valid), 32'h1);

    // Reset pulse after four data bits of 0xF0, with 0x81 still held.
    idle_bits(1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(negedge clk);
    sck = 1'b0;
    rx  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_data",  32'(data),       32'h0);
    chk("mid_rst_valid", 32'(data_valid), 32'h0);
    chk("mid_rst_ovr",   32'(overrun),    32'h0);
    chk("mid_rst_ferr",  32'(frame_err),  32'h0);
    l0 = loads.size();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_bit(1'b1);
    idle_bits(2);
    chk("mid_rst_loads", 32'(loads.size() - l0), 32'd0);
    chk("mid_rst_trail_valid", 32'(data_valid),  32'h0);
    send_frame(8'h5A, 1'b1);
    idle_bits(1);
    chk("post_rst_data",  32'(data),       32'h5A);
    chk("post_rst_valid", 32'(data_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Deserialises the 300-baud serial stream into bytes, using the recovered bit clock `sck` from the clock-recovery stage, which runs in the same 16x `clk` domain. Frames 8N1 characters (start, 8 data LSB-first, stop) and holds each received byte in an output register with a valid/ack handshake. It sits between clock recovery and the command/register logic that consumes received bytes.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `TIMEOUT`, 32: number of `clk` cycles without an `sck` rising edge, mid-frame, that aborts the frame.
- `clk` in 1: 16x baud clock, same clock as clock recovery.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial line, idle high.
- `sck` in 1: recovered bit clock, registered in the `clk` domain; rises at mid-bit.
- `data` out `DATA_BITS`: last good byte.
- `data_valid` out 1: `data` holds an unacknowledged byte.
- `data_ack` in 1: consumer accepts `data`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: sticky flag; a byte completed while `data_valid` was still high.

## Operation
- `rx` passes through a 2-flop synchroniser, giving `rxs`. No synchroniser on `sck`.
- `sck_d` is `sck` delayed one `clk`. `tick = sck & ~sck_d`. All bit sampling uses `rxs` in the cycle where `tick=1`.
- State machine states: IDLE, DATA, STOP, BREAK. States live in the shared package.
- IDLE:
  - `tick & ~rxs` -> DATA; bit count cleared to 0.
  - `tick & rxs` -> stay in IDLE.
  - `sck` toggles continuously while the line is idle. Ticks with `rxs=1` are ignored.
- DATA:
  - On each `tick`, the shift register shifts right with `rxs` entering the MSB, so the result is LSB-first.
  - Bit count increments on each `tick`.
  - When the count reaches `DATA_BITS` -> STOP.
- STOP, on `tick`:
  - `rxs=1` -> load `data` from the shift register, set `data_valid`, -> IDLE. If `data_valid` was already 1 (and is not acked in this cycle), set `overrun`; `data` is overwritten with the new byte.
  - `rxs=0` -> pulse `frame_err`, discard the byte, -> BREAK.
- BREAK: `tick & rxs` -> IDLE. A held-low line must not be taken as a new start bit.
- Timeout: a counter clears on every `tick` and saturates at `TIMEOUT`. Reaching `TIMEOUT` in DATA or STOP -> IDLE with no outputs changed.
- Handshake:
  - `data_ack` while `data_valid=1` clears `data_valid` and `overrun` on the next edge.
  - `data_ack` while `data_valid=0` is ignored.
  - Ack and load in the same cycle: the load wins, so `data_valid` stays 1 and `overrun` is not set.
- Width: bit counter is `$clog2(DATA_BITS+1)` bits. Timeout counter is `$clog2(TIMEOUT+1)` bits and must not wrap.

## Timing
- Reset values: state IDLE, synchroniser flops 1, `sck_d` 0, `data` 0, `data_valid` 0, `frame_err` 0, `overrun` 0, all counters 0.
- A reset asserted mid-frame discards the partial byte and any held byte.
- `rx` to `rxs` latency: 2 `clk`.
- `data_valid` rises on the `clk` edge that closes the `tick` cycle of the stop bit, 1 clk after `sck` is first seen high.
- `frame_err` is high for exactly 1 clk, aligned with that same edge.
- `data` is stable while `data_valid=1`, unless an overrun occurs.
- One frame is 10 bit periods = 160 `clk`. The consumer has at least one full frame time to ack before an overrun.

## Structure
- Shared package `uart_pkg`:
  - state typedef (IDLE, DATA, STOP, BREAK);
  - `DATA_BITS_DEF = 8`;
  - `TIMEOUT_DEF = 32`.
- One sub-module, `sync2`: a 2-flop synchroniser with reset value 1. It is reusable for other async inputs.
- Frame FSM, shift register, counters and handshake live in `uart_rx` itself.

## Test plan
- Bench instantiates clock recovery feeding `uart_rx`, with 16 `clk` per bit. Send 0xA5 8N1 -> `data=0xA5`, `data_valid=1`, `frame_err=0`. Assert `data_ack` -> `data_valid=0` on the next edge.
- Back-to-back frames 0x00 then 0xFF, with the consumer acking after each byte -> two loads, no `overrun`.
- Send 0x3C, do not ack, then send 0xC3 -> `data=0xC3`, `overrun=1`. Then ack -> `data_valid=0`, `overrun=0`.
- Send a frame with the stop bit low, then hold `rx` low for 40 bit periods, then release -> a single `frame_err` pulse, no `data_valid`, FSM back in IDLE; the next 0x55 is received correctly.
- Stop `sck` toggling for 40 clk mid-DATA -> FSM returns to IDLE with no outputs changed; the next frame 0x81 is received correctly.
- Assert `rst` for 1 clk mid-frame, after 4 data bits -> all outputs at their reset values; the trailing bits produce no `data_valid`; the following frame 0x5A is received correctly.
